// File: rtl/spike_dispatcher_pkg.sv
// rtl/spike_dispatcher_pkg.sv - shared accelerator constants: address width, null address, dispatcher states
package spike_dispatcher_pkg;

  localparam int ACC_ADDR_W = 12;
  localparam logic [ACC_ADDR_W-1:0] ACC_NULL_ADDR = 12'hFFF;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage

// File: rtl/spike_fifo.sv
// rtl/spike_fifo.sv - single-clock spike address FIFO with occupancy count
module spike_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/spike_dispatcher.sv
// rtl/spike_dispatcher.sv - queues spike addresses and streams them to the MAC units, flushing per timestep
module spike_dispatcher
  import spike_dispatcher_pkg::*;
#(
  parameter int                ADDR_W       = ACC_ADDR_W,
  parameter int                FIFO_DEPTH   = 8,
  parameter int                CLEAR_CYCLES = 2,
  parameter logic [ADDR_W-1:0] NULL_ADDR    = ACC_NULL_ADDR
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          spike_valid,
  input  logic [ADDR_W-1:0]             spike_addr,
  output logic                          spike_ready,
  input  logic                          timestep_end,
  // downstream back-pressure: suppresses pops while high
  input  logic                          stall,
  output logic [ADDR_W-1:0]             source_address,
  output logic                          addr_valid,
  output logic                          clear,
  output logic                          done,
  output logic                          ts_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CCW = $clog2(CLEAR_CYCLES + 1);

  logic [1:0]        state;
  logic [CCW-1:0]    clr_cnt;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] fifo_data;

  assign spike_ready = (state == ST_RUN) && !fifo_full;
  assign push        = spike_valid && spike_ready && (spike_addr != NULL_ADDR);
  assign pop         = !fifo_empty && !stall && ((state == ST_RUN) || (state == ST_DRAIN));
  assign clear       = (state == ST_CLEAR);

  spike_fifo #(
    .W     (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (spike_addr),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= ST_RUN;
      clr_cnt        <= '0;
      done           <= 1'b0;
      ts_overrun     <= 1'b0;
      source_address <= NULL_ADDR;
      addr_valid     <= 1'b0;
    end else begin
      done           <= 1'b0;
      addr_valid     <= pop;
      source_address <= pop ? fifo_data : NULL_ADDR;
      if (timestep_end && (state != ST_RUN)) ts_overrun <= 1'b1;

      // DRAIN leaves only once the FIFO reads empty, so the last popped
      // address is shown before clear rises and the two never overlap.
      unique case (state)
        ST_RUN: begin
          if (timestep_end) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == CCW'(CLEAR_CYCLES - 1)) begin
            state <= ST_RUN;
            done  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + CCW'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_dispatcher.sv
// tb/tb_spike_dispatcher.sv - scoreboard bench for spike_dispatcher
module tb_spike_dispatcher;

  localparam logic [11:0] NULLA = 12'hFFF;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        spike_valid = 1'b0;
  logic [11:0] spike_addr = '0;
  logic        timestep_end = 1'b0;
  logic        stall = 1'b0;
  logic        spike_ready;
  logic [11:0] source_address;
  logic        addr_valid;
  logic        clear;
  logic        done;
  logic        ts_overrun;
  logic [3:0]  fifo_count;

  spike_dispatcher dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .spike_valid    (spike_valid),
    .spike_addr     (spike_addr),
    .spike_ready    (spike_ready),
    .timestep_end   (timestep_end),
    .stall          (stall),
    .source_address (source_address),
    .addr_valid     (addr_valid),
    .clear          (clear),
    .done           (done),
    .ts_overrun     (ts_overrun),
    .fifo_count     (fifo_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    int          due;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      if (addr_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pop: got addr %0d expected no pop", source_address);
        end else begin
          e = exp_q.pop_front();
          chk("pop_addr", source_address, e.addr);
          if (e.lat) chk("pop_latency", cyc, e.due);
        end
      end else begin
        chk("idle_null_addr", source_address, NULLA);
      end
      if (clear) chk("clear_excl_valid", addr_valid, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [11:0] a, input bit lat);
    int g;
    g = 0;
    spike_valid = 1'b1;
    spike_addr  = a;
    while (!spike_ready && g < 60) begin
      @(negedge CLK);
      g++;
    end
    if (!spike_ready) begin
      chk("send_timeout", 0, 1);
      spike_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    if (a != NULLA) exp_q.push_back('{a, cyc + 1, lat});
    spike_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] av_v, clr_v, dn_v, rdy_v;
    int dn_cnt, av_cnt;

    // reset state
    @(negedge CLK);
    chk("rst_ready", spike_ready, 1);
    chk("rst_valid", addr_valid, 0);
    chk("rst_src", source_address, NULLA);
    chk("rst_clear", clear, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", ts_overrun, 0);
    chk("rst_count", fifo_count, 0);
    RST_N = 1'b1;
    tick(1);

    // scenario 1: back-to-back pushes into an empty FIFO, one-cycle latency
    send(12'd0, 1'b1);
    send(12'd1, 1'b1);
    send(12'd2, 1'b1);
    tick(5);
    chk("s1_drained", exp_q.size(), 0);

    // scenario 5: null address consumed, never enqueued
    chk("s5_ready", spike_ready, 1);
    send(NULLA, 1'b0);
    chk("s5_count", fifo_count, 0);
    tick(3);
    chk("s5_no_valid", addr_valid, 0);

    // scenario 2: fill under stall, back-pressure, then drain
    stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send(12'h100 + 12'(i), 1'b0);
      end
      begin
        int g;
        g = 0;
        while (fifo_count != 4'd8 && g < 40) begin
          @(negedge CLK);
          g++;
        end
        chk("s2_full_count", fifo_count, 8);
        chk("s2_ready_low", spike_ready, 0);
        tick(3);
        chk("s2_still_full", fifo_count, 8);
        stall = 1'b0;
      end
    join
    tick(15);
    chk("s2_all_popped", exp_q.size(), 0);
    chk("s2_count_zero", fifo_count, 0);

    // scenario 3: drain three queued entries then clear and done
    stall = 1'b1;
    send(12'h020, 1'b0);
    send(12'h021, 1'b0);
    send(12'h022, 1'b0);
    timestep_end = 1'b1;
    tick(1);
    timestep_end = 1'b0;
    chk("s3_ready_drain", spike_ready, 0);
    chk("s3_count", fifo_count, 3);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      av_v[i]  = addr_valid;
      clr_v[i] = clear;
      dn_v[i]  = done;
      rdy_v[i] = spike_ready;
    end
    chk("s3_valid_seq", av_v, 8'b0000_0111);
    chk("s3_clear_seq", clr_v, 8'b0001_1000);
    chk("s3_done_seq", dn_v, 8'b0010_0000);
    chk("s3_ready_seq", rdy_v, 8'b1110_0000);
    chk("s3_ovr", ts_overrun, 0);

    // scenario 4: timestep_end during CLEAR sets sticky overrun
    timestep_end = 1'b1;
    tick(1);
    timestep_end = 1'b0;
    tick(1);
    chk("s4_in_clear", clear, 1);
    timestep_end = 1'b1;
    tick(1);
    timestep_end = 1'b0;
    chk("s4_ovr_set", ts_overrun, 1);
    dn_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (done) dn_cnt++;
    end
    chk("s4_single_done", dn_cnt, 1);
    chk("s4_ovr_sticky", ts_overrun, 1);
    chk("s4_back_run", spike_ready, 1);

    // scenario 6: reset in DRAIN aborts the flush
    stall = 1'b1;
    send(12'h030, 1'b0);
    send(12'h031, 1'b0);
    timestep_end = 1'b1;
    tick(1);
    timestep_end = 1'b0;
    chk("s6_in_drain", spike_ready, 0);
    chk("s6_count", fifo_count, 2);
    RST_N = 1'b0;
    #1;
    chk("s6_rst_src", source_address, NULLA);
    chk("s6_rst_valid", addr_valid, 0);
    chk("s6_rst_clear", clear, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_ovr", ts_overrun, 0);
    chk("s6_rst_count", fifo_count, 0);
    chk("s6_rst_ready", spike_ready, 1);
    exp_q.delete();
    tick(1);
    RST_N = 1'b1;
    stall = 1'b0;
    dn_cnt = 0;
    av_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (done) dn_cnt++;
      if (addr_valid) av_cnt++;
    end
    chk("s6_no_done", dn_cnt, 0);
    chk("s6_no_pops", av_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
